// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - decode stage with registered ID/EX boundary; `HAZARD_DETECT_EN enables load-use bubbles
module decode_stage_pipe #(
   parameter int               INSTR_W   = 20,
   parameter int               OPC_W     = 4,
   parameter int               REG_AW    = 4,
   parameter logic [OPC_W-1:0] STORE_OPC = 4'b1100,
   parameter logic [OPC_W-1:0] LOAD_OPC  = 4'b1011
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   input  logic               ex_stall,
   input  logic               flush,
   output logic [REG_AW-1:0]  rf_raddr1,
   output logic [REG_AW-1:0]  rf_raddr2,
   output logic               ex_valid,
   output logic [INSTR_W-1:0] ex_instr,
   output logic [REG_AW-1:0]  ex_waddr,
   output logic               ex_wen,
   output logic               ex_is_load,
   output logic               ex_is_store
);

   localparam int T = INSTR_W - OPC_W;

   logic [OPC_W-1:0]  opc;
   logic [REG_AW-1:0] f0, f1, f2;
   logic [REG_AW-1:0] src1, src2;
   logic              is_store, is_load;
   logic              haz;

   assign opc      = in_instr[INSTR_W-1 -: OPC_W];
   assign f0       = in_instr[T-1 -: REG_AW];
   assign f1       = in_instr[T-1-REG_AW -: REG_AW];
   assign f2       = in_instr[T-1-2*REG_AW -: REG_AW];
   assign is_store = (opc == STORE_OPC);
   assign is_load  = (opc == LOAD_OPC);

   // Stores read data (F0) and base (F1); everything else reads F1/F2 and writes F0
   always_comb begin
      src1 = f1;
      src2 = f2;
      if (is_store) begin
         src1 = f0;
         src2 = f1;
      end
   end

   assign rf_raddr1 = src1;
   assign rf_raddr2 = src2;

`ifdef HAZARD_DETECT_EN
   // Load in EX whose result a source of the decoding instruction needs
   always_comb begin
      haz = in_valid & ex_valid & ex_is_load &
            ((ex_waddr == src1) | (ex_waddr == src2));
   end
`else
   // Load-use ordering is left to the compiler or a forwarding unit
   always_comb begin
      haz = 1'b0;
   end
`endif

   assign in_ready = ~ex_stall & ~haz;

   // ID/EX register: flush beats stall, stall beats bubble, bubble beats load
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_valid    <= 1'b0;
         ex_instr    <= '0;
         ex_waddr    <= '0;
         ex_wen      <= 1'b0;
         ex_is_load  <= 1'b0;
         ex_is_store <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
         ex_wen   <= 1'b0;
      end else if (ex_stall) begin
         ex_valid <= ex_valid;
      end else if (haz) begin
         ex_valid <= 1'b0;
         ex_wen   <= 1'b0;
      end else begin
         ex_valid    <= in_valid;
         ex_instr    <= in_instr;
         ex_waddr    <= f0;
         ex_wen      <= in_valid & ~is_store;
         ex_is_load  <= is_load;
         ex_is_store <= is_store;
      end
   end

endmodule
